// File: rtl/disk_boot_loader_if.sv
// Bus bundle between the boot loader, its host/disk environment and memory.
// The slave modport is the loader's view and the master modport is the environment's view.
interface disk_boot_loader_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [31:0]      src_s;
   logic [31:0]      src_t;
   logic [31:0]      dst_addr;
   logic [CNT_W-1:0] word_count;
   logic [31:0]      disk_s;
   logic [31:0]      disk_t;
   logic [31:0]      disk_data;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             busy;
   logic             done;

   modport master (
      output start, src_s, src_t, dst_addr, word_count, disk_data,
      input  disk_s, disk_t, mem_we, mem_addr, mem_wdata, busy, done
   );

   modport slave (
      input  start, src_s, src_t, dst_addr, word_count, disk_data,
      output disk_s, disk_t, mem_we, mem_addr, mem_wdata, busy, done
   );
endinterface

// File: rtl/disk_boot_loader.sv
// Copies word_count consecutive disk words, starting at (src_s, src_t), into
// word-addressed memory starting at dst_addr. Each word takes one READ and one WRITE cycle.
module disk_boot_loader #(
   parameter int TRACKS_PER_SECTOR = 2,
   parameter int CNT_W             = 16
) (
   input logic               clk,
   input logic               reset,
   disk_boot_loader_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [32:0] TPS_W = 33'(TRACKS_PER_SECTOR);

   state_t           state_r, state_s;
   logic [31:0]      disk_s_r, disk_s_s;
   logic [31:0]      disk_t_r, disk_t_s;
   logic [31:0]      mem_addr_r, mem_addr_s;
   logic [31:0]      mem_wdata_r, mem_wdata_s;
   logic [CNT_W-1:0] remaining_r, remaining_s;
   logic [32:0]      t_inc_s;

   // State and datapath registers; reset aborts any copy in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         disk_s_r    <= 32'd0;
         disk_t_r    <= 32'd0;
         mem_addr_r  <= 32'd0;
         mem_wdata_r <= 32'd0;
         remaining_r <= '0;
      end else begin
         state_r     <= state_s;
         disk_s_r    <= disk_s_s;
         disk_t_r    <= disk_t_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         remaining_r <= remaining_s;
      end
   end

   // Next-state and next-datapath logic.
   always_comb begin
      state_s     = state_r;
      disk_s_s    = disk_s_r;
      disk_t_s    = disk_t_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      remaining_s = remaining_r;
      // Widened so a track value near 2^32 cannot wrap past the sector boundary test.
      t_inc_s     = {1'b0, disk_t_r} + 33'd1;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               disk_s_s    = bus.src_s;
               disk_t_s    = bus.src_t;
               mem_addr_s  = bus.dst_addr;
               remaining_s = bus.word_count;
               state_s     = (bus.word_count == '0) ? DONE : READ;
            end else begin
               state_s = IDLE;
            end
         end
         READ: begin
            mem_wdata_s = bus.disk_data;
            state_s     = WRITE;
         end
         WRITE: begin
            mem_addr_s  = mem_addr_r + 32'd1;
            remaining_s = remaining_r - CNT_W'(1);
            if (t_inc_s >= TPS_W) begin
               disk_t_s = 32'd0;
               disk_s_s = disk_s_r + 32'd1;
            end else begin
               disk_t_s = t_inc_s[31:0];
            end
            state_s = (remaining_r == CNT_W'(1)) ? DONE : READ;
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign bus.disk_s    = disk_s_r;
   assign bus.disk_t    = disk_t_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.mem_we    = (state_r == WRITE);
   assign bus.busy      = (state_r != IDLE);
   assign bus.done      = (state_r == DONE);
endmodule

// File: tb/tb_disk_boot_loader.sv
// Self-checking bench for disk_boot_loader: the disk is a linear word array and
// the reference model computes every expected write from the linear word index.
module tb_disk_boot_loader;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   disk_boot_loader_if #(.CNT_W(16)) bus();

   disk_boot_loader #(.TRACKS_PER_SECTOR(2), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Disk model: word index = s*2 + t, folded onto a 64-word array.
   logic [31:0] disk_arr [64];
   logic [5:0]  disk_idx;
   assign disk_idx      = 6'(bus.disk_s * 32'd2 + bus.disk_t);
   assign bus.disk_data = disk_arr[disk_idx];

   // Monitor of memory writes and status pulses.
   logic [31:0] wr_addr_q[$], wr_data_q[$], wr_s_q[$], wr_t_q[$];
   int busy_total = 0;
   int done_total = 0;
   int done_cyc   = 0;
   always @(negedge clk) begin
      if (bus.mem_we) begin
         wr_addr_q.push_back(bus.mem_addr);
         wr_data_q.push_back(bus.mem_wdata);
         wr_s_q.push_back(bus.disk_s);
         wr_t_q.push_back(bus.disk_t);
      end
      if (bus.busy) busy_total <= busy_total + 1;
      if (bus.done) begin
         done_total <= done_total + 1;
         done_cyc   <= cyc;
      end
   end

   // Reference model outputs.
   logic [31:0] exp_addr[$], exp_data[$], exp_s[$], exp_t[$];
   logic [31:0] fin_s, fin_t, fin_addr;
   int e0;

   task automatic model_copy(input logic [31:0] s0, input logic [31:0] t0,
                             input logic [31:0] dst, input int n);
      logic [63:0] w;
      exp_addr.delete(); exp_data.delete(); exp_s.delete(); exp_t.delete();
      for (int k = 0; k < n; k++) begin
         w = {32'd0, s0} * 64'd2 + {32'd0, t0} + 64'(k);
         exp_s.push_back(w[32:1]);
         exp_t.push_back({31'd0, w[0]});
         exp_addr.push_back(dst + 32'(k));
         exp_data.push_back(disk_arr[w[5:0]]);
      end
      w        = {32'd0, s0} * 64'd2 + {32'd0, t0} + 64'(n);
      fin_s    = w[32:1];
      fin_t    = {31'd0, w[0]};
      fin_addr = dst + 32'(n);
   endtask

   task automatic do_start(input logic [31:0] s0, input logic [31:0] t0,
                           input logic [31:0] dst, input int n);
      @(posedge clk); #1;
      bus.src_s      = s0;
      bus.src_t      = t0;
      bus.dst_addr   = dst;
      bus.word_count = 16'(n);
      bus.start      = 1'b1;
      @(posedge clk); #1;
      e0        = cyc;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0; bus.src_s = 32'd0; bus.src_t = 32'd0;
      bus.dst_addr = 32'd0; bus.word_count = 16'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checks++;
      if (bus.disk_s !== 32'd0 || bus.disk_t !== 32'd0 || bus.mem_addr !== 32'd0 ||
          bus.mem_wdata !== 32'd0 || bus.mem_we !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got s=%h t=%h a=%h d=%h we=%b busy=%b done=%b want all 0",
                  bus.disk_s, bus.disk_t, bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.busy, bus.done);
      end
      @(posedge clk); #1 reset = 1'b0;
   endtask

   task automatic test_basic_copy();
      int base, d0; bit ok;
      logic [31:0] ea[2], ed[2];
      ea[0] = 32'h10; ea[1] = 32'h11; ed[0] = 32'h04210002; ed[1] = 32'h50200000;
      base = wr_addr_q.size(); d0 = done_total;
      do_start(32'd0, 32'd0, 32'h10, 2);
      wait_idle(40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout: busy still 1 want 0"); end
      checks++;
      if (wr_addr_q.size() - base != 2) begin
         errors++; $display("FAIL basic_count: got %0d writes want 2", wr_addr_q.size() - base);
      end else begin
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (wr_addr_q[base+k] !== ea[k] || wr_data_q[base+k] !== ed[k]) begin
               errors++;
               $display("FAIL basic_write[%0d]: got a=%h d=%h want a=%h d=%h",
                        k, wr_addr_q[base+k], wr_data_q[base+k], ea[k], ed[k]);
            end
         end
      end
      checks++;
      if (done_total - d0 != 1 || done_cyc - e0 != 4) begin
         errors++;
         $display("FAIL basic_done: got %0d pulses at +%0d want 1 at +4", done_total - d0, done_cyc - e0);
      end
   endtask

   task automatic test_zero_count();
      int base, d0, b0; bit ok;
      base = wr_addr_q.size(); d0 = done_total; b0 = busy_total;
      do_start(32'h7, 32'd1, 32'h200, 0);
      wait_idle(10, ok);
      @(posedge clk); #1;
      checks++;
      if (!ok || done_total - d0 != 1 || done_cyc != e0) begin
         errors++;
         $display("FAIL zero_done: got ok=%b pulses=%0d at +%0d want 1 at +0", ok, done_total - d0, done_cyc - e0);
      end
      checks++;
      if (busy_total - b0 != 1 || wr_addr_q.size() != base) begin
         errors++;
         $display("FAIL zero_busy_we: got busy=%0d writes=%0d want busy=1 writes=0",
                  busy_total - b0, wr_addr_q.size() - base);
      end
      checks++;
      if (bus.disk_s !== 32'h7 || bus.disk_t !== 32'd1 || bus.mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL zero_final: got s=%h t=%h a=%h want 7 1 200", bus.disk_s, bus.disk_t, bus.mem_addr);
      end
   endtask

   task automatic test_track_walk();
      int base; bit ok;
      model_copy(32'd3, 32'd1, 32'h40, 3);
      base = wr_addr_q.size();
      do_start(32'd3, 32'd1, 32'h40, 3);
      wait_idle(40, ok);
      checks++;
      if (!ok || wr_addr_q.size() - base != 3) begin
         errors++; $display("FAIL walk_count: got ok=%b writes=%0d want 3", ok, wr_addr_q.size() - base);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_s_q[base+k] !== exp_s[k] || wr_t_q[base+k] !== exp_t[k] ||
                wr_data_q[base+k] !== exp_data[k] || wr_addr_q[base+k] !== exp_addr[k]) begin
               errors++;
               $display("FAIL walk_read[%0d]: got (%0d,%0d) d=%h want (%0d,%0d) d=%h", k,
                        wr_s_q[base+k], wr_t_q[base+k], wr_data_q[base+k], exp_s[k], exp_t[k], exp_data[k]);
            end
         end
      end
      checks++;
      if (bus.disk_s !== 32'd5 || bus.disk_t !== 32'd0 || bus.mem_addr !== 32'h43) begin
         errors++;
         $display("FAIL walk_final: got s=%0d t=%0d a=%h want 5 0 43", bus.disk_s, bus.disk_t, bus.mem_addr);
      end
   endtask

   task automatic test_ignore_start();
      int base, d0, b0, n;
      n = 3;
      model_copy(32'd10, 32'd0, 32'h80, n);
      base = wr_addr_q.size(); d0 = done_total; b0 = busy_total;
      do_start(32'd10, 32'd0, 32'h80, n);
      for (int k = 1; k <= 2*n + 4; k++) begin
         @(posedge clk); #1;
         if (k == 2 || k == 2*n) begin
            bus.src_s = $urandom; bus.src_t = 32'd1;
            bus.dst_addr = $urandom; bus.word_count = 16'd5;
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
      end
      checks++;
      if (wr_addr_q.size() - base != n || done_total - d0 != 1 || busy_total - b0 != 2*n + 1) begin
         errors++;
         $display("FAIL ignore_counts: got writes=%0d done=%0d busy=%0d want %0d 1 %0d",
                  wr_addr_q.size() - base, done_total - d0, busy_total - b0, n, 2*n + 1);
      end else begin
         for (int k = 0; k < n; k++) begin
            checks++;
            if (wr_addr_q[base+k] !== exp_addr[k] || wr_data_q[base+k] !== exp_data[k]) begin
               errors++;
               $display("FAIL ignore_write[%0d]: got a=%h d=%h want a=%h d=%h",
                        k, wr_addr_q[base+k], wr_data_q[base+k], exp_addr[k], exp_data[k]);
            end
         end
      end
      checks++;
      if (bus.disk_s !== fin_s || bus.disk_t !== fin_t || bus.mem_addr !== fin_addr || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_final: got s=%h t=%h a=%h busy=%b want %h %h %h 0",
                  bus.disk_s, bus.disk_t, bus.mem_addr, bus.busy, fin_s, fin_t, fin_addr);
      end
   endtask

   task automatic test_reset_midcopy();
      int base, cnt; bit seen; bit ok;
      base = wr_addr_q.size(); seen = 1'b0;
      do_start(32'd20, 32'd1, 32'h300, 4);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wr_addr_q.size() > base) begin seen = 1'b1; break; end
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (!seen || bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.mem_addr !== 32'd0) begin
         errors++;
         $display("FAIL midreset_abort: got seen=%b we=%b busy=%b a=%h want 1 0 0 0",
                  seen, bus.mem_we, bus.busy, bus.mem_addr);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (wr_addr_q.size() - base != 1) begin
         errors++; $display("FAIL midreset_writes: got %0d writes want 1", wr_addr_q.size() - base);
      end
      model_copy(32'd2, 32'd0, 32'h500, 3);
      base = wr_addr_q.size();
      do_start(32'd2, 32'd0, 32'h500, 3);
      wait_idle(40, ok);
      cnt = wr_addr_q.size() - base;
      checks++;
      if (!ok || cnt != 3) begin
         errors++; $display("FAIL midreset_recopy_count: got ok=%b writes=%0d want 3", ok, cnt);
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_addr_q[base+k] !== exp_addr[k] || wr_data_q[base+k] !== exp_data[k]) begin
               errors++;
               $display("FAIL midreset_recopy[%0d]: got a=%h d=%h want a=%h d=%h",
                        k, wr_addr_q[base+k], wr_data_q[base+k], exp_addr[k], exp_data[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      int base, d0, n; bit ok;
      logic [31:0] s0, t0, dst;
      for (int it = 0; it < 8; it++) begin
         s0  = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
         t0  = 32'($urandom_range(0, 1));
         dst = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFE : $urandom;
         n   = $urandom_range(0, 6);
         model_copy(s0, t0, dst, n);
         base = wr_addr_q.size(); d0 = done_total;
         do_start(s0, t0, dst, n);
         wait_idle(40, ok);
         checks++;
         if (!ok || wr_addr_q.size() - base != n || done_total - d0 != 1 || done_cyc - e0 != 2*n) begin
            errors++;
            $display("FAIL rand%0d_shape: got ok=%b writes=%0d done=%0d at +%0d want %0d 1 +%0d",
                     it, ok, wr_addr_q.size() - base, done_total - d0, done_cyc - e0, n, 2*n);
         end else begin
            for (int k = 0; k < n; k++) begin
               checks++;
               if (wr_addr_q[base+k] !== exp_addr[k] || wr_data_q[base+k] !== exp_data[k] ||
                   wr_s_q[base+k] !== exp_s[k] || wr_t_q[base+k] !== exp_t[k]) begin
                  errors++;
                  $display("FAIL rand%0d_write[%0d]: got a=%h d=%h (%h,%h) want a=%h d=%h (%h,%h)",
                           it, k, wr_addr_q[base+k], wr_data_q[base+k], wr_s_q[base+k], wr_t_q[base+k],
                           exp_addr[k], exp_data[k], exp_s[k], exp_t[k]);
               end
            end
         end
         checks++;
         if (bus.disk_s !== fin_s || bus.disk_t !== fin_t || bus.mem_addr !== fin_addr) begin
            errors++;
            $display("FAIL rand%0d_final: got s=%h t=%h a=%h want %h %h %h",
                     it, bus.disk_s, bus.disk_t, bus.mem_addr, fin_s, fin_t, fin_addr);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) disk_arr[i] = $urandom;
      disk_arr[0] = 32'h04210002;
      disk_arr[1] = 32'h50200000;
      test_reset();
      test_basic_copy();
      test_zero_count();
      test_track_walk();
      test_ignore_start();
      test_reset_midcopy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
